// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency-gate measurement block.
//   freq_state_t     : sequencer states
//   CNT_W_DEF        : default edge-counter / result width
//   MAX_COUNT_DEF    : default saturation value (largest displayable count)
//   RANGE_LOW_THRESH : a fast-range result below this drops back to the slow range
package freq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2,
        ST_HOLD  = 2'd3
    } freq_state_t;

    localparam int CNT_W_DEF        = 16;
    localparam int MAX_COUNT_DEF    = 9999;
    localparam int RANGE_LOW_THRESH = 900;

endpackage

// File: rtl/freq_gate_ctrl_sig_sync_edge.sv
// Brings the asynchronous measured signal into the clk domain and produces a
// one-cycle pulse on each synchronised rising edge.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-low reset (clears all flops)
//   din   - asynchronous input
//   rise  - one-cycle pulse, high while the 2nd sync flop is 1 and the 3rd is 0
module sig_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Frequency measurement sequencer: counts synchronised rising edges of sigin
// inside a gate window of exact length, latches a saturated result, holds it
// for a display interval and restarts while run is high.
// Optional feature macro: FREQ_AUTORANGE_EN (gate length selected by range).
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-low reset
//   sigin      - asynchronous measured signal
//   run        - 1 = keep measuring, 0 = stop (abort if in the gate)
//   freq       - last latched edge count
//   freq_valid - one-cycle pulse when freq updates
//   overflow   - last measurement exceeded MAX_COUNT
//   busy       - high in GATE, LATCH, HOLD
//   gate       - high while edges are counted
//   range      - 1 = short gate (GATE_CYCLES/10); tied 0 without the feature
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for run, count held at 0
// ST_GATE  | counting edge pulses, gate timer running
// ST_LATCH | one cycle: publish count/overflow, load hold timer
// ST_HOLD  | display hold, then restart or go idle
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int HOLD_CYCLES = 10_000_000,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MAX_COUNT   = MAX_COUNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sigin,
    input  logic             run,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy,
    output logic             gate,
    output logic             range
);

    localparam int TMR_MAX = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] GATE_LOAD = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_COUNT);

    freq_state_t      state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [TMR_W-1:0] gate_load;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] freq_nxt;
    logic             ovf_flag, ovf_flag_nxt;
    logic             overflow_nxt;
    logic             valid_nxt;
    logic             rise;

    sig_sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sigin),
        .rise  (rise)
    );

`ifdef FREQ_AUTORANGE_EN
    localparam int GATE_SHORT = (GATE_CYCLES / 10 > 0) ? GATE_CYCLES / 10 : 1;
    localparam logic [TMR_W-1:0] GATE_LOAD_SHORT = TMR_W'(GATE_SHORT - 1);
    localparam logic [CNT_W-1:0] RANGE_LOW       = CNT_W'(RANGE_LOW_THRESH);

    logic range_q, range_nxt;

    always_ff @(posedge clk) begin
        if (!reset) range_q <= 1'b0;
        else        range_q <= range_nxt;
    end

    // range is updated in LATCH, so a reload from HOLD already sees the new value
    assign gate_load = range_q ? GATE_LOAD_SHORT : GATE_LOAD;
    assign range     = range_q;
`else
    assign gate_load = GATE_LOAD;
    assign range     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            count      <= '0;
            ovf_flag   <= 1'b0;
            freq       <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            count      <= count_nxt;
            ovf_flag   <= ovf_flag_nxt;
            freq       <= freq_nxt;
            freq_valid <= valid_nxt;
            overflow   <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        count_nxt    = count;
        ovf_flag_nxt = ovf_flag;
        freq_nxt     = freq;
        valid_nxt    = 1'b0;
        overflow_nxt = overflow;
`ifdef FREQ_AUTORANGE_EN
        range_nxt    = range_q;
`endif
        case (state)
            ST_IDLE: begin
                count_nxt    = '0;
                ovf_flag_nxt = 1'b0;
                if (run) begin
                    timer_nxt = gate_load;
                    state_nxt = ST_GATE;
                end
            end
            ST_GATE: begin
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else begin
                    // the edge seen on the terminal-count cycle still belongs to the window
                    if (rise) begin
                        if (count == CNT_MAX) ovf_flag_nxt = 1'b1;
                        else                  count_nxt    = count + CNT_W'(1);
                    end
                    if (timer == '0) state_nxt = ST_LATCH;
                    else             timer_nxt = timer - TMR_W'(1);
                end
            end
            ST_LATCH: begin
                freq_nxt     = count;
                overflow_nxt = ovf_flag;
                valid_nxt    = 1'b1;
                timer_nxt    = HOLD_LOAD;
                state_nxt    = ST_HOLD;
`ifdef FREQ_AUTORANGE_EN
                if (!range_q && ovf_flag)         range_nxt = 1'b1;
                else if (range_q && count < RANGE_LOW) range_nxt = 1'b0;
`endif
            end
            ST_HOLD: begin
                if (timer == '0) begin
                    if (run) begin
                        timer_nxt    = gate_load;
                        count_nxt    = '0;
                        ovf_flag_nxt = 1'b0;
                        state_nxt    = ST_GATE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign gate = (state == ST_GATE);
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_freq_gate_ctrl.sv
`timescale 1ns/1ps
module tb_freq_gate_ctrl;

    localparam int GATE = 1000;
    localparam int HOLD = 100;
    localparam int MAXC = 99;
    localparam int CW   = 16;
    localparam int HIST = 100000;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          sigin = 1'b0;
    logic          run   = 1'b0;
    logic [CW-1:0] freq;
    logic          freq_valid;
    logic          overflow;
    logic          busy;
    logic          gate;
    logic          range;

    freq_gate_ctrl #(
        .GATE_CYCLES (GATE),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CW),
        .MAX_COUNT   (MAXC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sigin      (sigin),
        .run        (run),
        .freq       (freq),
        .freq_valid (freq_valid),
        .overflow   (overflow),
        .busy       (busy),
        .gate       (gate),
        .range      (range)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // cyc = index of the clock interval that follows the most recent rising edge
    int cyc = 0;
    bit sig_hist [HIST];
    int sig_mode   = 0;   // 0: static level, 1: square wave
    bit sig_level  = 1'b0;
    int sig_period = 20;
    int sig_phase  = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (sig_mode == 1)
                sigin = (((cyc + sig_phase) % sig_period) < (sig_period / 2)) ? 1'b1 : 1'b0;
            else
                sigin = sig_level;
            if (cyc < HIST) sig_hist[cyc] = sigin;
        end
    end

    // valid-pulse recorder
    int            q_cyc [$];
    logic [CW-1:0] q_freq[$];
    logic          q_ovf [$];
    logic          q_rng [$];

    always @(negedge clk) begin
        if (freq_valid === 1'b1) begin
            q_cyc.push_back(cyc);
            q_freq.push_back(freq);
            q_ovf.push_back(overflow);
            q_rng.push_back(range);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    bit m_range = 1'b0;
    int m_freq  = 0;
    bit m_ovf   = 1'b0;

    function automatic int glen();
        return m_range ? GATE / 10 : GATE;
    endfunction

    // A sigin rise first driven in interval i is seen by the counter in
    // interval i+2; the window is intervals g .. g+len-1.
    function automatic void model_meas(input int g, input int len);
        int raw = 0;
        for (int i = g - 2; i <= g + len - 3; i++)
            if (i >= 1 && i < HIST && sig_hist[i] && !sig_hist[i-1]) raw++;
        m_freq = (raw > MAXC) ? MAXC : raw;
        m_ovf  = (raw > MAXC);
`ifdef FREQ_AUTORANGE_EN
        if (!m_range && m_ovf)          m_range = 1'b1;
        else if (m_range && m_freq < 900) m_range = 1'b0;
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_run(output int g, output int len);
        @(posedge clk);
        #2;
        q_cyc.delete(); q_freq.delete(); q_ovf.delete(); q_rng.delete();
        run = 1'b1;
        g   = cyc + 1;
        len = glen();
    endtask

    task automatic wait_valid(input int limit, output bit ok, output int vc,
                              output logic [CW-1:0] vf, output logic vo, output logic vr);
        int n = 0;
        ok = 1'b0; vc = 0; vf = '0; vo = 1'b0; vr = 1'b0;
        while (q_cyc.size() == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (q_cyc.size() > 0) begin
            ok = 1'b1;
            vc = q_cyc.pop_front();
            vf = q_freq.pop_front();
            vo = q_ovf.pop_front();
            vr = q_rng.pop_front();
        end
    endtask

    task automatic stop_run(output bit ok);
        int n = 0;
        run = 1'b0;
        while (busy !== 1'b0 && n < GATE + HOLD + 20) begin
            @(negedge clk);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; run = 1'b1;
        sig_mode = 1; sig_period = 4; sig_phase = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({freq, freq_valid, overflow, busy, gate, range} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got freq=%0d valid=%b ovf=%b busy=%b gate=%b range=%b, expected all 0",
                     freq, freq_valid, overflow, busy, gate, range);
        end
        run = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({freq, freq_valid, overflow, busy, gate, range} !== '0) begin
            n_fail++;
            $display("FAIL reset_release got freq=%0d valid=%b ovf=%b busy=%b gate=%b range=%b, expected all 0",
                     freq, freq_valid, overflow, busy, gate, range);
        end
        n_checks++;
        if (q_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL reset_no_valid got %0d pulses expected 0", q_cyc.size());
        end
        m_freq = 0; m_ovf = 1'b0; m_range = 1'b0;
    endtask

    task automatic test_nominal();
        int g, len, vc; bit ok; logic [CW-1:0] vf; logic vo, vr;
        sig_mode = 1; sig_period = 20; sig_phase = $urandom_range(0, 19);
        start_run(g, len);
        goto(g); @(negedge clk);
        n_checks++;
        if ({gate, busy} !== 2'b11) begin
            n_fail++; $display("FAIL nominal_gate_open got gate=%b busy=%b expected 1 1", gate, busy);
        end
        goto(g + len); @(negedge clk);
        n_checks++;
        if ({gate, busy} !== 2'b01) begin
            n_fail++; $display("FAIL nominal_latch_status got gate=%b busy=%b expected 0 1", gate, busy);
        end
        for (int k = 0; k < 2; k++) begin
            wait_valid(len + HOLD + 20, ok, vc, vf, vo, vr);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL nominal_timeout meas %0d: no freq_valid", k);
            end else begin
                model_meas(g, len);
                n_checks++;
                if (vc != g + len + 1) begin n_fail++; $display("FAIL nominal_valid_time got %0d expected %0d", vc, g + len + 1); end
                n_checks++;
                if (vf !== CW'(m_freq)) begin n_fail++; $display("FAIL nominal_freq got %0d expected %0d", vf, m_freq); end
                n_checks++;
                if (vo !== m_ovf) begin n_fail++; $display("FAIL nominal_ovf got %b expected %b", vo, m_ovf); end
                g   = g + len + HOLD + 1;
                len = glen();
            end
        end
        stop_run(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL nominal_stop busy=%b expected 0", busy); end
    endtask

    task automatic test_saturation();
        int g, len, vc; bit ok; logic [CW-1:0] vf; logic vo, vr;
        sig_mode = 1; sig_period = 4; sig_phase = $urandom_range(0, 3);
        start_run(g, len);
        for (int k = 0; k < 2; k++) begin
            wait_valid(len + HOLD + 20, ok, vc, vf, vo, vr);
            sig_period = 20;
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL sat_timeout meas %0d: no freq_valid", k);
            end else begin
                model_meas(g, len);
                n_checks++;
                if (vc != g + len + 1) begin n_fail++; $display("FAIL sat_valid_time got %0d expected %0d", vc, g + len + 1); end
                n_checks++;
                if (vf !== CW'(m_freq)) begin n_fail++; $display("FAIL sat_freq got %0d expected %0d", vf, m_freq); end
                n_checks++;
                if (vo !== m_ovf) begin n_fail++; $display("FAIL sat_ovf got %b expected %b", vo, m_ovf); end
                n_checks++;
                if (vr !== m_range) begin n_fail++; $display("FAIL sat_range got %b expected %b", vr, m_range); end
                g   = g + len + HOLD + 1;
                len = glen();
            end
        end
        stop_run(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL sat_stop busy=%b expected 0", busy); end
    endtask

    task automatic test_random();
        int g, len, vc; bit ok; logic [CW-1:0] vf; logic vo, vr;
        sig_mode = 1; sig_period = $urandom_range(3, 40); sig_phase = $urandom_range(0, 39);
        start_run(g, len);
        for (int k = 0; k < 4; k++) begin
            wait_valid(len + HOLD + 20, ok, vc, vf, vo, vr);
            sig_period = $urandom_range(3, 40);
            sig_phase  = $urandom_range(0, 39);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL random_timeout meas %0d: no freq_valid", k);
            end else begin
                model_meas(g, len);
                n_checks++;
                if (vc != g + len + 1) begin n_fail++; $display("FAIL random_valid_time got %0d expected %0d", vc, g + len + 1); end
                n_checks++;
                if (vf !== CW'(m_freq)) begin n_fail++; $display("FAIL random_freq meas %0d got %0d expected %0d", k, vf, m_freq); end
                n_checks++;
                if (vo !== m_ovf) begin n_fail++; $display("FAIL random_ovf meas %0d got %b expected %b", k, vo, m_ovf); end
                g   = g + len + HOLD + 1;
                len = glen();
            end
        end
        stop_run(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL random_stop busy=%b expected 0", busy); end
    endtask

    task automatic test_abort();
        int g, len, vc; bit ok; logic [CW-1:0] vf; logic vo, vr;
        sig_mode = 1; sig_period = 16; sig_phase = $urandom_range(0, 15);
        start_run(g, len);
        goto(g + len / 2 - 1);
        run = 1'b0;
        goto(g + len / 2); @(negedge clk);
        n_checks++;
        if ({busy, gate} !== 2'b00) begin
            n_fail++; $display("FAIL abort_idle got busy=%b gate=%b expected 0 0", busy, gate);
        end
        wait_valid(len + HOLD + 20, ok, vc, vf, vo, vr);
        n_checks++;
        if (ok) begin n_fail++; $display("FAIL abort_valid_seen got pulse at %0d expected none", vc); end
        n_checks++;
        if (freq !== CW'(m_freq)) begin n_fail++; $display("FAIL abort_freq_kept got %0d expected %0d", freq, m_freq); end
        n_checks++;
        if (overflow !== m_ovf) begin n_fail++; $display("FAIL abort_ovf_kept got %b expected %b", overflow, m_ovf); end
        sig_period = 25;
        start_run(g, len);
        wait_valid(len + HOLD + 20, ok, vc, vf, vo, vr);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL abort_restart_timeout no freq_valid");
        end else begin
            model_meas(g, len);
            n_checks++;
            if (vc != g + len + 1) begin n_fail++; $display("FAIL abort_restart_time got %0d expected %0d", vc, g + len + 1); end
            n_checks++;
            if (vf !== CW'(m_freq)) begin n_fail++; $display("FAIL abort_restart_freq got %0d expected %0d", vf, m_freq); end
        end
        stop_run(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL abort_stop busy=%b expected 0", busy); end
    endtask

    task automatic test_boundary();
        int g, len, vc, exp_f; bit ok; logic [CW-1:0] vf; logic vo, vr;
        sig_mode = 0; sig_level = 1'b0;
        for (int k = 0; k < 2; k++) begin
            repeat (5) @(posedge clk);
            start_run(g, len);
            // a rise first driven in interval g+len-3 reaches the counter on the last gate cycle
            goto(g + len - 4 + k);
            sig_level = 1'b1;
            exp_f = (k == 0) ? 1 : 0;
            wait_valid(len + HOLD + 20, ok, vc, vf, vo, vr);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL boundary_timeout case %0d: no freq_valid", k);
            end else begin
                model_meas(g, len);
                n_checks++;
                if (vf !== CW'(exp_f)) begin n_fail++; $display("FAIL boundary_freq case %0d got %0d expected %0d", k, vf, exp_f); end
                n_checks++;
                if (vo !== 1'b0) begin n_fail++; $display("FAIL boundary_ovf case %0d got %b expected 0", k, vo); end
            end
            stop_run(ok);
            sig_level = 1'b0;
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL boundary_stop busy=%b expected 0", busy); end
        end
    endtask

    task automatic test_reset_mid();
        int g, len, vc; bit ok; logic [CW-1:0] vf; logic vo, vr;
        sig_mode = 1; sig_period = 7; sig_phase = 0;
        start_run(g, len);
        goto(g + len / 3);
        reset = 1'b0; run = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({freq, freq_valid, overflow, busy, gate, range} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got freq=%0d valid=%b ovf=%b busy=%b gate=%b range=%b, expected all 0",
                     freq, freq_valid, overflow, busy, gate, range);
        end
        reset = 1'b1;
        m_freq = 0; m_ovf = 1'b0; m_range = 1'b0;
        wait_valid(len + HOLD + 20, ok, vc, vf, vo, vr);
        n_checks++;
        if (ok) begin n_fail++; $display("FAIL reset_mid_valid_seen got pulse at %0d expected none", vc); end
    endtask

`ifdef FREQ_AUTORANGE_EN
    task automatic test_autorange();
        int g, len, vc; bit ok; logic [CW-1:0] vf; logic vo, vr;
        sig_mode = 1; sig_period = 4; sig_phase = 0;
        start_run(g, len);
        for (int k = 0; k < 3; k++) begin
            wait_valid(len + HOLD + 20, ok, vc, vf, vo, vr);
            if (k == 1) sig_period = 50;
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL autorange_timeout meas %0d: no freq_valid", k);
            end else begin
                model_meas(g, len);
                n_checks++;
                if (vc != g + len + 1) begin n_fail++; $display("FAIL autorange_time meas %0d got %0d expected %0d", k, vc, g + len + 1); end
                n_checks++;
                if (vf !== CW'(m_freq)) begin n_fail++; $display("FAIL autorange_freq meas %0d got %0d expected %0d", k, vf, m_freq); end
                n_checks++;
                if (vo !== m_ovf) begin n_fail++; $display("FAIL autorange_ovf meas %0d got %b expected %b", k, vo, m_ovf); end
                n_checks++;
                if (vr !== m_range) begin n_fail++; $display("FAIL autorange_range meas %0d got %b expected %b", k, vr, m_range); end
                g   = g + len + HOLD + 1;
                len = glen();
            end
        end
        stop_run(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL autorange_stop busy=%b expected 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_random();
        test_abort();
        test_boundary();
        test_reset_mid();
`ifdef FREQ_AUTORANGE_EN
        test_autorange();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
